// File: rtl/fifo_serial_drain_if.sv
// Read-port bundle between a jFIFO and its consumer.
// master = the consumer (drives rn), slave = the FIFO side.
interface fifo_serial_drain_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_wr_busy;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rn;

  modport master (
    input  fifo_empty,
    input  fifo_wr_busy,
    input  fifo_data,
    output fifo_rn
  );

  modport slave (
    output fifo_empty,
    output fifo_wr_busy,
    output fifo_data,
    input  fifo_rn
  );
endinterface

// File: rtl/fifo_serial_drain.sv
// Pops bytes from a jFIFO read port and sends each as a serial frame:
// start bit, DATA_W data bits LSB first, stop bit.
module fifo_serial_drain #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  fifo_serial_drain_if.master fifo,
  output logic                tx_line,
  output logic                tx_busy,
  output logic                byte_done,
  output logic [CNT_W-1:0]    frame_count
);

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic               tx_q, tx_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               bit_end;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      baud_q        <= '0;
      tx_q          <= 1'b1;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      baud_q        <= baud_d;
      tx_q          <= tx_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bit_end = (baud_q == LAST_BAUD);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    baud_d        = baud_q;
    tx_d          = tx_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo.fifo_empty) state_d = S_REQ;
      end
      // rn stays up until the FIFO is not writing, since it drops pops then
      S_REQ: begin
        if (fifo.fifo_empty)         state_d = S_IDLE;
        else if (!fifo.fifo_wr_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        shift_d = fifo.fifo_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d        = '0;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo.fifo_rn = (state_q == S_REQ);
  assign tx_line      = tx_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign byte_done    = (state_q == S_STOP) && bit_end;
  assign frame_count  = frame_count_q;

endmodule
